sumsq: RTL and testbench
========================

# sumsq

Sequential sum-of-squares stage that sits directly upstream of the `sqrt` block: it takes one signed complex sample (I, Q) per transaction and computes I² + Q² with a shared shift-add multiplier. The result is an unsigned 2W+1-bit word on `sq_out`. For the default W = 8 this is the 17-bit argument format `sqrt` expects on `x_in`, so the pair yields |I + jQ|. The block uses a valid/ready handshake on both sides and holds `sq_out` stable between results, because `sqrt` samples its input continuously.

## Interface
- `W`, default 8: signed input width. The output is 2W+1 bits. The design supports W ≥ 2; the integration width is 8.
- `clk`  in  1: system clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `i_in`  in  W: in-phase sample, two's complement.
- `q_in`  in  W: quadrature sample, two's complement.
- `in_valid`  in  1: `i_in`/`q_in` are valid.
- `in_ready`  out  1: block can accept a sample. Equals (state == IDLE).
- `sq_out`  out  2W+1: unsigned I² + Q², registered.
- `out_valid`  out  1: `sq_out` holds a new result not yet consumed.
- `out_ready`  in  1: downstream consumes the result.
- `busy`  out  1: high in SQI, SQQ and DONE.

## Operation
- **States:** IDLE, SQI, SQQ, DONE.
- **IDLE:** `in_ready` = 1. On an edge with `in_valid` = 1:
  - latch |I| and |Q| as W-bit unsigned values; |−2^(W−1)| = 2^(W−1) fits unsigned;
  - clear the accumulator (2W+1 bits) and the bit counter;
  - load the multiplicand register (2W bits) = |I| and the multiplier shift register = |I|;
  - go to SQI.
- **SQI:** one bit per cycle.
  - If multiplier LSB = 1, accumulator += multiplicand.
  - Multiplicand shifts left 1, multiplier shifts right 1, counter increments.
  - After W cycles: reload multiplicand = |Q| and multiplier = |Q|, clear the counter, go to SQQ.
- **SQQ:** same bit-serial operation on |Q|, accumulating into the same accumulator. After W cycles go to DONE.
- **Entering DONE:** `sq_out` ← accumulator and `out_valid` ← 1 on the same edge.
- **DONE:** `out_valid` is held until an edge with `out_ready` = 1. On that edge `out_valid` ← 0 and the state goes to IDLE.
- **Data hold:** `sq_out` keeps its value after `out_valid` drops and changes only when the next result is written.
- **Arithmetic:** all unsigned after the abs step.
  - The maximum result is 2·2^(2W−2) = 2^(2W−1), so no overflow is possible at 2W+1 bits.
  - No rounding or saturation.
- **Input sampling:** inputs are sampled only on the accept edge. Changes on `i_in`/`q_in` during computation are ignored.
- **Reset:** state IDLE, `out_valid` 0, `sq_out` 0, `busy` 0, `in_ready` 1, accumulator/counter/shift registers 0.
  - Reset mid-computation or in DONE aborts the transaction; no result is produced.
  - Reset has priority over every handshake on the same edge.

## Timing
- **Latency:** acceptance on edge E0 gives `out_valid` = 1 after edge E0+2W (16 cycles for W = 8).
- **Cycles per state:** SQI occupies edges E1..EW; SQQ occupies EW+1..E2W.
- **`in_ready` timing:** low from the cycle after acceptance until the cycle after the `out_ready` consume edge.
- **No overlap:** a sample cannot be accepted on the same edge that a result is consumed.
- **Throughput:**
  - Minimum interval between accept edges is 2W+2 cycles (18 for W = 8) when `out_ready` is held high.
  - Backpressure adds one cycle per cycle that `out_ready` is low in DONE.
- **Combinational paths:** `out_ready` has no path to `in_ready` or to any output. All outputs except `in_ready`/`busy` (state decodes) are registers.

## Test plan
- **Basic:** I = 3, Q = 4, `in_valid` one cycle, `out_ready` = 1.
  - Required: `sq_out` = 25 with `out_valid` high exactly 16 cycles after the accept edge, for one cycle.
  - Required: `in_ready` returns next cycle.
- **Extremes:**
  - I = −128, Q = −128 → 32768 (0x08000).
  - I = 127, Q = −128 → 32513.
  - I = 0, Q = 0 → 0, with `out_valid` still asserted.
- **Backpressure:** I = −5, Q = 12, `out_ready` low for 5 cycles after `out_valid` rises.
  - Required: `out_valid` stays 1, `sq_out` = 169 stable, `in_ready` = 0 throughout.
  - Required: consume on the first `out_ready` = 1 edge.
- **Back-to-back:** `in_valid` held high with samples (1,1), (2,−3), (−7,0).
  - Required: accepts every 18 cycles; results 2, 13, 49 in order; `sq_out` holds 2 between results 1 and 2.
- **Input churn:** change `i_in`/`q_in` every cycle during SQI/SQQ.
  - Required: result reflects only the values on the accept edge.
- **Reset:** assert `reset` for one cycle at the 5th cycle of SQI.
  - Required: `out_valid` never rises for that sample, `sq_out` = 0, `in_ready` = 1 on the next cycle.
  - Required: the next sample (6,8) yields 100.

Source files
------------

// File: rtl/sumsq.sv
// Bit-serial sum-of-squares stage: accepts a signed (I, Q) pair and produces
// the unsigned I^2 + Q^2 on a held output register with valid/ready handshakes.
module sumsq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   i_in,
  input  logic [W-1:0]   q_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W:0]   sq_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int unsigned OW = 2 * W + 1;
  localparam int unsigned MW = 2 * W;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQI  = 2'd1,
    SQQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [W-1:0]    abs_q_q;
  logic [MW-1:0]   mcand_q;
  logic [W-1:0]    mplier_q;
  logic [OW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   sq_out_q;
  logic            out_valid_q;

  logic [W-1:0]    abs_i_c;
  logic [W-1:0]    abs_q_c;
  logic [OW-1:0]   acc_d;
  logic            last_bit_c;

  // Magnitudes of the raw samples; the most negative value maps to 2^(W-1).
  always_comb begin
    abs_i_c = i_in[W-1] ? W'(-i_in) : i_in;
    abs_q_c = q_in[W-1] ? W'(-q_in) : q_in;
  end

  // One shift-add step of the shared multiplier.
  always_comb begin
    acc_d      = acc_q + (mplier_q[0] ? OW'(mcand_q) : OW'(0));
    last_bit_c = (cnt_q == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      abs_q_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sq_out_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            abs_q_q  <= abs_q_c;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= MW'(abs_i_c);
            mplier_q <= abs_i_c;
            state_q  <= SQI;
          end
        end
        SQI: begin
          acc_q <= acc_d;
          if (last_bit_c) begin
            mcand_q  <= MW'(abs_q_q);
            mplier_q <= abs_q_q;
            cnt_q    <= '0;
            state_q  <= SQQ;
          end else begin
            mcand_q  <= {mcand_q[MW-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[W-1:1]};
            cnt_q    <= cnt_q + CW'(1);
          end
        end
        SQQ: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[MW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[W-1:1]};
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit_c) begin
            sq_out_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sq_out    = sq_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sumsq.sv
// Directed bench for sumsq (W = 8): vector table plus handshake corner sequences.
module tb_sumsq;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [7:0]  i_in;
  logic signed [7:0]  q_in;
  logic               in_valid;
  logic               in_ready;
  logic [16:0]        sq_out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic signed [7:0] i;
    logic signed [7:0] q;
    int                exp;
  } vec_t;

  vec_t vecs[6];

  sumsq #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_in      (i_in),
    .q_in      (q_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sq_out    (sq_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  // Accept one sample with out_ready high; verify latency, value and release.
  task automatic run_vec(input logic signed [7:0] vi, input logic signed [7:0] vq,
                         input int exp, input string nm);
    int n;
    @(negedge clk);
    chk({nm, " in_ready before accept"}, int'(in_ready), 1);
    i_in = vi; q_in = vq; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " in_ready after accept"}, int'(in_ready), 0);
    chk({nm, " busy after accept"}, int'(busy), 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 16);
    chk({nm, " sq_out"}, int'(sq_out), exp);
    @(negedge clk);
    chk({nm, " out_valid one cycle"}, int'(out_valid), 0);
    chk({nm, " in_ready after consume"}, int'(in_ready), 1);
  endtask

  logic signed [7:0] bi[3];
  logic signed [7:0] bq[3];
  int                bexp[3];

  initial begin
    int n, last_acc, bad;

    vecs[0] = '{i: 8'sd3,    q: 8'sd4,    exp: 25};
    vecs[1] = '{i: -8'sd128, q: -8'sd128, exp: 32768};
    vecs[2] = '{i: 8'sd127,  q: -8'sd128, exp: 32513};
    vecs[3] = '{i: 8'sd0,    q: 8'sd0,    exp: 0};
    vecs[4] = '{i: -8'sd1,   q: 8'sd1,    exp: 2};
    vecs[5] = '{i: -8'sd128, q: 8'sd127,  exp: 32513};
    bi = '{8'sd1, 8'sd2, -8'sd7};
    bq = '{8'sd1, -8'sd3, 8'sd0};
    bexp = '{2, 13, 49};

    reset = 1'b1; i_in = '0; q_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset sq_out", int'(sq_out), 0);
    chk("reset busy", int'(busy), 0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++)
      run_vec(vecs[k].i, vecs[k].q, vecs[k].exp, $sformatf("vec%0d", k));

    // Backpressure: hold the result for five cycles.
    out_ready = 1'b0;
    @(negedge clk);
    i_in = -8'sd5; q_in = 8'sd12; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp latency", n, 16);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp out_valid held c%0d", c), int'(out_valid), 1);
      chk($sformatf("bp sq_out stable c%0d", c), int'(sq_out), 169);
      chk($sformatf("bp in_ready low c%0d", c), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp consumed out_valid", int'(out_valid), 0);
    chk("bp consumed in_ready", int'(in_ready), 1);
    chk("bp sq_out held after consume", int'(sq_out), 169);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 3; k++) begin
      i_in = bi[k]; q_in = bq[k];
      n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (k == 1) chk("b2b hold at second accept", int'(sq_out), 2);
      if (k > 0) chk($sformatf("b2b accept interval %0d", k), cyc - last_acc, 18);
      last_acc = cyc;
      @(negedge clk);
      n = 0;
      while (!out_valid && n < 40) begin
        if (k == 1 && n == 8) chk("b2b hold mid compute", int'(sq_out), 2);
        @(negedge clk);
        n++;
      end
      chk($sformatf("b2b result %0d", k), int'(sq_out), bexp[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Input churn during computation.
    @(negedge clk);
    i_in = 8'sd9; q_in = -8'sd10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      i_in = 8'($urandom); q_in = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk("churn latency", n, 16);
    chk("churn sq_out", int'(sq_out), 181);
    @(negedge clk);

    // Reset on the fifth SQI edge aborts the sample.
    i_in = 8'sd7; q_in = 8'sd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort in_ready", int'(in_ready), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort sq_out cleared", int'(sq_out), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("abort no result", bad, 0);
    run_vec(8'sd6, 8'sd8, 100, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
